result_collector: RTL and testbench

- Write-side counterpart to the X/W source memory: the sink that captures the 32-bit IEEE-754 single-precision outputs produced by the 4-neuron Maxnet datapath.
- Accepts one word per valid/ready handshake and stores words in arrival order in a DEPTH-entry register array.
- Flags when the array is full.
- Tracks how many stored values are strictly positive, so the controller can detect Maxnet termination (exactly one survivor).
- Exposes an asynchronous read port for the controller and testbench.

---
 rtl/result_collector.sv | 106 ++++++++++
 tb/tb_result_collector.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Result sink for the Maxnet datapath: captures IEEE-754 words in arrival order
// and tracks how many are strictly positive so the controller can spot a lone survivor.
module result_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic [CW-1:0]    pos_count,
  output logic [AW-1:0]    winner_idx,
  output logic             single_winner,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pos_count_q, pos_count_d;
  logic [AW-1:0]    winner_q, winner_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic accept;
  logic in_pos;

  // Sign clear and a non-zero magnitude; both signed zeros are excluded.
  assign in_pos   = !in_data[WIDTH-1] && (|in_data[WIDTH-2:0]);
  assign full     = (state_q == ST_FULL);
  assign in_ready = !full && !clr;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pos_count_q <= '0;
      winner_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pos_count_q <= pos_count_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pos_count_d = pos_count_q;
    winner_d    = winner_q;
    if (clr) begin
      state_d     = ST_EMPTY;
      wr_ptr_d    = '0;
      count_d     = '0;
      pos_count_d = '0;
      winner_d    = '0;
    end else if (accept) begin
      count_d = count_q + 1'b1;
      state_d = (count_q == CW'(DEPTH - 1)) ? ST_FULL : ST_FILLING;
      // Pointer parks on the last slot; the FULL state blocks further writes.
      if (wr_ptr_q != AW'(DEPTH - 1)) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (in_pos) begin
        pos_count_d = pos_count_q + 1'b1;
        winner_d    = wr_ptr_q;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (clr) begin
        mem_q[gi] <= '0;
      end else if (accept && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= in_data;
      end
    end
  end

  assign count         = count_q;
  assign pos_count     = pos_count_q;
  assign winner_idx    = winner_q;
  assign single_winner = full && (pos_count_q == CW'(1));
  assign rd_data       = mem_q[rd_addr];

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed scenarios plus random traffic, all compared
// against a queue-based model of the stored words.
module tb_result_collector;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic             clk = 0;
  logic             rst_n = 0;
  logic             clr = 0;
  logic             in_valid = 0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic [CW-1:0]    pos_count;
  logic [AW-1:0]    winner_idx;
  logic             single_winner;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;

  int total = 0;
  int bad = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .count(count), .full(full), .pos_count(pos_count),
    .winner_idx(winner_idx), .single_winner(single_winner),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  function automatic bit is_pos(logic [31:0] w);
    return (w < 32'h8000_0000) && (w != 32'h0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int pc = 0;
    int wi = 0;
    foreach (q[i]) if (is_pos(q[i])) begin pc++; wi = i; end
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("pos_count", 32'(pos_count), 32'(pc));
    chk("winner_idx", 32'(winner_idx), 32'(wi));
    chk("single_winner", 32'(single_winner), 32'((q.size() == DEPTH) && (pc == 1)));
    chk("in_ready", 32'(in_ready), 32'((q.size() != DEPTH) && !clr));
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      #1;
      chk($sformatf("rd_data[%0d]", a), rd_data, (a < q.size()) ? q[a] : 32'h0);
    end
    $display("cycle t=%0t rst_n=%0b clr=%0b valid=%0b data=%08h count=%0d pos=%0d win=%0d",
             $time, rst_n, clr, in_valid, in_data, count, pos_count, winner_idx);
  endtask

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic cycle();
    bit acc;
    logic [31:0] d;
    acc = rst_n && !clr && in_valid && (q.size() < DEPTH);
    d = in_data;
    @(posedge clk);
    if (!rst_n || clr) q.delete();
    else if (acc) q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data = d;
    cycle();
  endtask

  logic [31:0] s1 [4] = '{32'h3f800000, 32'hbe4ccccd, 32'hbe4ccccd, 32'hbe4ccccd};
  logic [31:0] s2 [4] = '{32'h3e99999a, 32'h00000000, 32'h80000000, 32'h3f000000};
  logic [31:0] tw [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    // Reset held two cycles with a valid word offered.
    rst_n = 0;
    drive(1, 32'hcafef00d);
    drive(1, 32'hcafef00d);
    rst_n = 1;
    in_valid = 0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'h1);
    chk("count_after_reset", 32'(count), 32'h0);

    // Stream with one survivor.
    for (int i = 0; i < 4; i++) drive(1, s1[i]);
    in_valid = 0;
    chk("s1_pos_count", 32'(pos_count), 32'd1);
    chk("s1_winner", 32'(winner_idx), 32'd0);
    chk("s1_single", 32'(single_winner), 32'd1);
    chk("s1_full", 32'(full), 32'd1);

    // Writes while full are ignored.
    for (int i = 0; i < 3; i++) drive(1, 32'h12345678);
    chk("full_hold_word3", q[3], 32'hbe4ccccd);
    in_valid = 0;
    clr = 1;
    cycle();
    clr = 0;

    // Signed zeros are not positive.
    for (int i = 0; i < 4; i++) drive(1, s2[i]);
    chk("s2_pos_count", 32'(pos_count), 32'd2);
    chk("s2_winner", 32'(winner_idx), 32'd3);
    chk("s2_single", 32'(single_winner), 32'd0);
    in_valid = 0;
    clr = 1;
    cycle();
    clr = 0;

    // Clear mid-fill drops the coincident word.
    drive(1, 32'h01020304);
    drive(1, 32'h05060708);
    clr = 1;
    drive(1, 32'hdeadbeef);
    clr = 0;
    chk("clr_count", 32'(count), 32'd0);
    drive(1, 32'haabbccdd);
    rd_addr = '0;
    #1;
    chk("after_clr_idx0", rd_data, 32'haabbccdd);
    in_valid = 0;
    clr = 1;
    cycle();
    clr = 0;

    // Toggled valid with a reset pulse after the second accept.
    for (int i = 0; i < 8; i++) begin
      drive(!i[0], tw[i/2]);
      if (i == 3) begin
        rst_n = 0;
        drive(0, 32'h0);
        rst_n = 1;
      end
    end
    rd_addr = '0;
    #1;
    chk("toggle_idx0", rd_data, tw[2]);
    chk("toggle_count", 32'(count), 32'd2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [31:0] d;
      kind = int'($urandom_range(0, 5));
      case (kind)
        0: d = 32'h0;
        1: d = 32'h8000_0000;
        2: d = $urandom() | 32'h8000_0000;
        default: d = $urandom();
      endcase
      clr = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 39) != 0);
      drive($urandom_range(0, 2) != 0, d);
    end
    rst_n = 1;
    clr = 0;
    in_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
